// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer
// Packs four received UART bytes (little-endian) into a 32-bit word and
// queues completed words in a small FIFO whose head is presented as a
// registered, first-word fall-through output.
// Optional feature: define UART_RX_TIMEOUT_EN to discard a partial word
// after TIMEOUT_CYCLES idle clocks.
module uart_rx_word_packer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 104160
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_byte_valid,
  input  logic                       rd_ack,
  input  logic                       clr_overrun,
  output logic [31:0]                rx_word,
  output logic                       rx_word_valid,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [1:0]                 byte_idx,
  output logic                       overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2,
    BYTE3 = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [23:0]        partial_r;
  logic [23:0]        partial_nxt_s;
  logic [31:0]        mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_nxt_s;
  logic [31:0]        head_nxt_s;
  logic [31:0]        push_word_s;
  logic               push_req_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               drop_s;
  logic               timeout_s;

  // The completed word is the incoming fourth byte on top of the three held ones
  assign push_word_s = {rx_byte, partial_r};
  assign push_req_s  = rx_byte_valid && (state_r == BYTE3);
  assign pop_s       = rd_ack && (fifo_level != LVL_W'(0));
  assign full_s      = (fifo_level == LVL_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds
  assign push_s      = push_req_s && (!full_s || pop_s);
  assign drop_s      = push_req_s && full_s && !pop_s;

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);

  logic [16:0] idle_cnt_r;

  assign timeout_s = (state_r != BYTE0) && (idle_cnt_r == TIMEOUT_LAST);

  // Idle counter: cleared by any byte, parked in BYTE0, restarts after a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_r <= 17'd0;
    end else if (rx_byte_valid || (state_r == BYTE0) || timeout_s) begin
      idle_cnt_r <= 17'd0;
    end else begin
      idle_cnt_r <= idle_cnt_r + 17'd1;
    end
  end
`else
  // No idle timeout: the term is constant false for any legal TIMEOUT_CYCLES
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  // Packer next state: a byte strobe takes priority over an idle timeout
  always_comb begin
    state_nxt_s   = state_r;
    partial_nxt_s = partial_r;
    if (rx_byte_valid) begin
      case (state_r)
        BYTE0: begin
          partial_nxt_s[7:0] = rx_byte;
          state_nxt_s        = BYTE1;
        end
        BYTE1: begin
          partial_nxt_s[15:8] = rx_byte;
          state_nxt_s         = BYTE2;
        end
        BYTE2: begin
          partial_nxt_s[23:16] = rx_byte;
          state_nxt_s          = BYTE3;
        end
        BYTE3: begin
          partial_nxt_s = 24'd0;
          state_nxt_s   = BYTE0;
        end
        default: begin
          partial_nxt_s = 24'd0;
          state_nxt_s   = BYTE0;
        end
      endcase
    end else if (timeout_s) begin
      partial_nxt_s = 24'd0;
      state_nxt_s   = BYTE0;
    end else begin
      partial_nxt_s = partial_r;
      state_nxt_s   = state_r;
    end
  end

  // FIFO occupancy: simultaneous push and pop leave the level unchanged
  always_comb begin
    level_nxt_s = fifo_level;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = fifo_level + LVL_W'(1);
      2'b01:   level_nxt_s = fifo_level - LVL_W'(1);
      default: level_nxt_s = fifo_level;
    endcase
  end

  // Next head word: the entry behind the popped one, or the word being pushed
  // when it lands in an empty (or just-emptied) FIFO
  always_comb begin
    head_nxt_s = rx_word;
    if (pop_s) begin
      if (level_nxt_s == LVL_W'(0)) begin
        head_nxt_s = 32'd0;
      end else if (fifo_level == LVL_W'(1)) begin
        head_nxt_s = push_word_s;
      end else begin
        head_nxt_s = mem_r[rd_ptr_r + PTR_W'(1)];
      end
    end else if (push_s && (fifo_level == LVL_W'(0))) begin
      head_nxt_s = push_word_s;
    end else begin
      head_nxt_s = rx_word;
    end
  end

  // FIFO storage: no reset needed, validity is tracked by pointers and level
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  // Packer state, pointers and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= BYTE0;
      partial_r     <= 24'd0;
      wr_ptr_r      <= PTR_W'(0);
      rd_ptr_r      <= PTR_W'(0);
      fifo_level    <= LVL_W'(0);
      rx_word       <= 32'd0;
      rx_word_valid <= 1'b0;
      fifo_full     <= 1'b0;
      byte_idx      <= 2'd0;
      overrun       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      partial_r     <= partial_nxt_s;
      byte_idx      <= state_nxt_s;
      fifo_level    <= level_nxt_s;
      rx_word       <= head_nxt_s;
      rx_word_valid <= (level_nxt_s != LVL_W'(0));
      fifo_full     <= (level_nxt_s == LVL_W'(DEPTH));
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      // A drop in the same cycle as a clear keeps the flag set
      if (drop_s) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer: directed scenarios followed by
// random traffic, compared every cycle against a queue-based reference model.
module tb_uart_rx_word_packer;

  localparam int DEPTH = 4;
  localparam int TO    = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_byte_valid = 1'b0;
  logic        rd_ack = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [31:0] rx_word;
  logic        rx_word_valid;
  logic        fifo_full;
  logic [2:0]  fifo_level;
  logic [1:0]  byte_idx;
  logic        overrun;

  int vecs = 0;
  int errs = 0;

  // Reference model state
  logic [31:0] exp_fifo[$];
  logic [7:0]  part_q[$];
  logic        exp_ovr = 1'b0;
  int          idle = 0;

  uart_rx_word_packer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rd_ack(rd_ack), .clr_overrun(clr_overrun), .rx_word(rx_word),
    .rx_word_valid(rx_word_valid), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .byte_idx(byte_idx), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] head;
    head = (exp_fifo.size() != 0) ? exp_fifo[0] : 32'd0;
    chk("rx_word", rx_word, head);
    chk("rx_word_valid", {31'd0, rx_word_valid}, {31'd0, exp_fifo.size() != 0});
    chk("fifo_full", {31'd0, fifo_full}, {31'd0, exp_fifo.size() == DEPTH});
    chk("fifo_level", {29'd0, fifo_level}, 32'(exp_fifo.size()));
    chk("byte_idx", {30'd0, byte_idx}, 32'(part_q.size()));
    chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
  endtask

  // One clock: drive inputs, advance the model by the same event, then compare
  task automatic cycle(input logic v, input logic [7:0] b, input logic ack, input logic clr);
    logic        pop;
    logic        drop;
    logic [31:0] w;
    @(negedge clk);
    rx_byte_valid = v;
    rx_byte       = b;
    rd_ack        = ack;
    clr_overrun   = clr;
    @(posedge clk);
    pop  = ack && (exp_fifo.size() != 0);
    drop = 1'b0;
    if (pop) void'(exp_fifo.pop_front());
    if (v) begin
      idle = 0;
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        w = {part_q[3], part_q[2], part_q[1], part_q[0]};
        part_q.delete();
        if (exp_fifo.size() < DEPTH) exp_fifo.push_back(w);
        else drop = 1'b1;
      end
    end else begin
      idle++;
`ifdef UART_RX_TIMEOUT_EN
      if (idle >= TO) part_q.delete();
`endif
    end
    if (drop) exp_ovr = 1'b1;
    else if (clr) exp_ovr = 1'b0;
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) cycle(1'b1, w[8*k +: 8], 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 8'($urandom), 1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; effect checked before the next edge
  task automatic do_reset();
    @(negedge clk);
    rx_byte_valid = 1'b0;
    rd_ack        = 1'b0;
    clr_overrun   = 1'b0;
    rst           = 1'b1;
    exp_fifo.delete();
    part_q.delete();
    exp_ovr = 1'b0;
    idle    = 0;
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();

    // First word, visible one cycle after the 4th strobe
    send_word(32'h44332211);
    chk("tp_first_word", rx_word, 32'h44332211);
    chk("tp_first_idx", {30'd0, byte_idx}, 32'd0);
    pop_one();

    // Fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) send_word({4{8'(8'h10 + i)}});
    chk("tp_full", {31'd0, fifo_full}, 32'd1);
    send_word(32'hDEADBEEF);
    chk("tp_overrun", {31'd0, overrun}, 32'd1);
    chk("tp_head_kept", rx_word, 32'h10101010);
    // Clear and a drop in the same cycle: set wins
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    chk("tp_set_wins", {31'd0, overrun}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("tp_clr", {31'd0, overrun}, 32'd0);

    // Push and pop together while full
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'(32'hCAFEF00D >> (8*k)), 1'b0, 1'b0);
    cycle(1'b1, 8'hCA, 1'b1, 1'b0);
    chk("tp_pp_level", {29'd0, fifo_level}, 32'd4);
    chk("tp_pp_ovr", {31'd0, overrun}, 32'd0);
    for (int k = 0; k < 3; k++) pop_one();
    chk("tp_pp_last", rx_word, 32'hCAFEF00D);

    // Drain, then acknowledges on an empty FIFO
    for (int k = 0; k < 3; k++) pop_one();
    chk("tp_empty_level", {29'd0, fifo_level}, 32'd0);
    chk("tp_empty_word", rx_word, 32'd0);

    // Ten words across pointer wrap
    for (int i = 0; i < 10; i++) begin
      send_word($urandom);
      if (i % 3 == 2) for (int k = 0; k < 3; k++) pop_one();
    end
    for (int k = 0; k < 5; k++) pop_one();

    // Reset mid-word discards everything
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    cycle(1'b1, 8'h88, 1'b0, 1'b0);
    do_reset();
    chk("tp_rst_idx", {30'd0, byte_idx}, 32'd0);
    send_word(32'h12345678);
    chk("tp_rst_word", rx_word, 32'h12345678);
    pop_one();

    // Idle period with a partial word held
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    for (int k = 0; k < TO; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    chk("tp_to_idx", {30'd0, byte_idx}, 32'd0);
`else
    chk("tp_to_idx", {30'd0, byte_idx}, 32'd2);
`endif
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'(8'hA1 + k), 1'b0, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    chk("tp_to_word", rx_word, 32'hA4A3A2A1);
`else
    chk("tp_to_word", rx_word, 32'hA2A1BBAA);
`endif
    for (int k = 0; k < 2; k++) pop_one();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
